req_wbuf: RTL and testbench
===========================

# req_wbuf

Posted-write buffer stage inserted between the request arbiter and the SDRAM request controller. It accepts one request at a time from the arbiter and gathers a write burst into a local FIFO, completing the write towards the master without waiting for SDRAM. It then replays the buffered burst downstream as one back-to-back transfer. Reads pass through with one cycle of added request latency, and are strictly ordered behind any buffered write.

## Interface
Parameters:
- LW, 8: request length width; burst = req_len + 1 words
- MW, 4: byte-mask width
- DW, 32: data width
- AW, 32: address width
- FW, 8: FIFO depth log2; must satisfy FW >= LW so any burst fits

Ports:
- clk  in  1  system clock (sys_clk domain)
- rstn  in  1  asynchronous, active-low reset
- s_req_valid  in  1  upstream request valid
- s_req_ready  out  1  upstream request accepted
- s_req_addr / s_req_mask / s_req_len / s_req_we / s_req_wrap  in  AW/MW/LW/1/1  request fields
- s_write_valid  in  1  upstream write-word strobe; no backpressure
- s_write_data  in  DW  upstream write word
- s_read_valid  out  1  read word valid to upstream
- s_read_data  out  DW  read word to upstream
- s_read_ack  in  1  upstream accepts read word
- m_req_valid / m_req_ready  out/in  1  downstream request handshake
- m_req_addr / m_req_mask / m_req_len / m_req_we / m_req_wrap  out  AW/MW/LW/1/1  registered request fields
- m_write_valid  out  1  downstream write-word strobe
- m_write_data  out  DW  downstream write word
- m_read_valid  in  1  downstream read word valid
- m_read_data  in  DW  downstream read word
- m_read_ack  out  1  ack to downstream
- err  out  1  sticky protocol-error flag; present only with REQ_WBUF_ERR_EN

## Operation
- States: IDLE, WCOLLECT, WISSUE, WDRAIN, RISSUE, RDATA.
- IDLE:
  - s_req_ready = 1.
  - On s_req_valid & s_req_ready, the block latches all fields and clears the word counter.
  - Next state is WCOLLECT if we = 1, otherwise RISSUE.
- WCOLLECT:
  - Each s_write_valid pushes s_write_data and increments the counter.
  - When the counter reaches len + 1, next state is WISSUE.
- WISSUE / RISSUE:
  - m_req_valid = 1 with the latched fields; the fields stay stable until m_req_ready.
  - On handshake, WISSUE goes to WDRAIN and RISSUE goes to RDATA.
- WDRAIN:
  - m_write_valid = 1 for exactly len + 1 consecutive cycles, popping the FIFO in order.
  - After the last word, next state is IDLE.
- RDATA:
  - Combinational passthrough: s_read_valid = m_read_valid, s_read_data = m_read_data, m_read_ack = s_read_ack.
  - Each transferred word (valid & ack) increments the counter.
  - After word len + 1, next state is IDLE.
- Ordering: a new request cannot be accepted until WDRAIN completes, so a read never overtakes a buffered write.
- Mask and wrap are forwarded unchanged. The FIFO pointers wrap modulo 2^FW, and the FIFO is empty again at the end of every WDRAIN.
- Outside WCOLLECT, s_write_valid is ignored. Outside RDATA, m_read_valid is ignored and m_read_ack = 0.

## Timing
- Reset values, all 0: s_req_ready, m_req_valid, m_write_valid, m_read_ack, s_read_valid, err.
- s_req_ready is registered and rises on the first clk edge after rstn deasserts.
- Handshake rules:
  - s_req_ready drops the cycle after acceptance.
  - The first s_write_valid may arrive no earlier than the cycle after acceptance.
  - m_req_valid must not drop before m_req_ready.
- Latencies:
  - Last s_write_valid at cycle t gives m_req_valid at t+1.
  - The m_req handshake at t gives the first m_write_valid at t+1.
  - A read request accepted at t gives m_req_valid at t+1.
  - Read data has zero added latency.
  - The last m_write_valid or last read ack at t gives s_req_ready at t+1.
- A simultaneous m_req_ready on the first m_req_valid cycle is legal (single-cycle issue).
- rstn asserted mid-operation: the state returns to IDLE immediately and all buffered data is discarded. Downstream must be reset in the same domain.

## Configuration
- REQ_WBUF_ERR_EN defined: err is present and is set (until reset) by any of:
  - s_write_valid outside WCOLLECT;
  - m_read_valid outside RDATA;
  - s_read_ack without s_read_valid.
- REQ_WBUF_ERR_EN undefined: the err port and its logic are absent; violations are silently ignored.

## Structure
- Shared package req_pkg holds:
  - the LW/MW/DW/AW default constants, reused by the arbiter, decoder and SDRAM controller;
  - the req_wbuf state encoding.
- Sub-module wbuf_fifo: synchronous FIFO, 2^FW x DW, with registered read data, push/pop, and async active-low reset on pointers only. Storage is inferred as block RAM.

## Test plan
- Reset: hold rstn = 0 for 5 cycles → all outputs 0; s_req_ready = 1 exactly one cycle after release.
- Single write: addr 0x0000_0100, len 0, data 0xDEADBEEF → m_req_valid one cycle after the word; with m_req_ready tied to 1, one m_write_valid carrying 0xDEADBEEF, then s_req_ready.
- Full burst: len 255 with incrementing data, and m_req_ready delayed 10 cycles → 256 m_write_valid cycles back-to-back, data in order, fields stable throughout the stall.
- Read burst: len 3, wrap = 1; m_read_valid each cycle with s_read_ack toggling → exactly 4 transfers forwarded, m_read_ack mirrors s_read_ack, and the block returns to IDLE after the 4th.
- Ordering: write len 7 immediately followed by a pending read → the read's m_req_valid appears only after the 8th m_write_valid.
- Reset mid-WDRAIN after 3 words, then a new write with len 0 → exactly one word is emitted, with no stale data (with REQ_WBUF_ERR_EN, also check that s_write_valid in IDLE sets err).

Source files
------------

// File: rtl/req_pkg.sv
// Shared request-path constants and the req_wbuf state encoding.
// Reused by the arbiter, decoder, SDRAM controller and req_wbuf.
package req_pkg;

  localparam int unsigned REQ_LW = 8;
  localparam int unsigned REQ_MW = 4;
  localparam int unsigned REQ_DW = 32;
  localparam int unsigned REQ_AW = 32;

  typedef enum logic [2:0] {
    StIdle,
    StWCollect,
    StWIssue,
    StWDrain,
    StRIssue,
    StRData
  } wbuf_state_e;

endpackage

// File: rtl/wbuf_fifo.sv
// Synchronous 2^FW x DW FIFO with registered read data.
// Only the pointers are reset so the storage maps onto block RAM.
module wbuf_fifo #(
  parameter int unsigned FW = 8,
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] pop_data_o
);

  localparam int unsigned Depth = 2 ** FW;
  localparam logic [FW-1:0] PtrOne = FW'(1);

  logic [DW-1:0] mem_q [Depth];
  logic [FW-1:0] wptr_q, rptr_q;
  logic [DW-1:0] pop_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PtrOne;
      if (pop_i)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= push_data_i;
    if (pop_i)  pop_data_q    <= mem_q[rptr_q];
  end

  assign pop_data_o = pop_data_q;

endmodule

// File: rtl/req_wbuf.sv
// Posted-write buffer between request arbiter and SDRAM controller; reads pass through in order.
// Define REQ_WBUF_ERR_EN to add the sticky protocol-error output err.
module req_wbuf
  import req_pkg::*;
#(
  parameter int unsigned LW = REQ_LW,
  parameter int unsigned MW = REQ_MW,
  parameter int unsigned DW = REQ_DW,
  parameter int unsigned AW = REQ_AW,
  parameter int unsigned FW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          s_req_valid,
  output logic          s_req_ready,
  input  logic [AW-1:0] s_req_addr,
  input  logic [MW-1:0] s_req_mask,
  input  logic [LW-1:0] s_req_len,
  input  logic          s_req_we,
  input  logic          s_req_wrap,
  input  logic          s_write_valid,
  input  logic [DW-1:0] s_write_data,
  output logic          s_read_valid,
  output logic [DW-1:0] s_read_data,
  input  logic          s_read_ack,
  output logic          m_req_valid,
  input  logic          m_req_ready,
  output logic [AW-1:0] m_req_addr,
  output logic [MW-1:0] m_req_mask,
  output logic [LW-1:0] m_req_len,
  output logic          m_req_we,
  output logic          m_req_wrap,
  output logic          m_write_valid,
  output logic [DW-1:0] m_write_data,
  input  logic          m_read_valid,
  input  logic [DW-1:0] m_read_data,
  output logic          m_read_ack
`ifdef REQ_WBUF_ERR_EN
  ,
  output logic          err
`endif
);

  localparam logic [LW:0] CntOne = (LW + 1)'(1);

  wbuf_state_e   state_q;
  logic [LW:0]   cnt_q;
  logic [AW-1:0] addr_q;
  logic [MW-1:0] mask_q;
  logic [LW-1:0] len_q;
  logic          we_q, wrap_q;
  logic          s_req_ready_q, m_req_valid_q, m_write_valid_q;

  logic last_cnt, push, pop, rd_xfer;

  assign last_cnt = (cnt_q == {1'b0, len_q});
  assign push     = (state_q == StWCollect) && s_write_valid;
  // Prefetch: the handshake pops word 0 so it is on m_write_data the first drain cycle.
  assign pop      = ((state_q == StWIssue) && m_req_ready) || ((state_q == StWDrain) && !last_cnt);
  assign rd_xfer  = (state_q == StRData) && m_read_valid && s_read_ack;

  wbuf_fifo #(
    .FW(FW),
    .DW(DW)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rstn),
    .push_i     (push),
    .push_data_i(s_write_data),
    .pop_i      (pop),
    .pop_data_o (m_write_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      addr_q          <= '0;
      mask_q          <= '0;
      len_q           <= '0;
      we_q            <= 1'b0;
      wrap_q          <= 1'b0;
      s_req_ready_q   <= 1'b0;
      m_req_valid_q   <= 1'b0;
      m_write_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s_req_ready_q && s_req_valid) begin
            addr_q        <= s_req_addr;
            mask_q        <= s_req_mask;
            len_q         <= s_req_len;
            we_q          <= s_req_we;
            wrap_q        <= s_req_wrap;
            cnt_q         <= '0;
            s_req_ready_q <= 1'b0;
            if (s_req_we) begin
              state_q <= StWCollect;
            end else begin
              state_q       <= StRIssue;
              m_req_valid_q <= 1'b1;
            end
          end else begin
            s_req_ready_q <= 1'b1;
          end
        end
        StWCollect: begin
          if (s_write_valid) begin
            cnt_q <= cnt_q + CntOne;
            if (last_cnt) begin
              state_q       <= StWIssue;
              m_req_valid_q <= 1'b1;
            end
          end
        end
        StWIssue: begin
          if (m_req_ready) begin
            m_req_valid_q   <= 1'b0;
            m_write_valid_q <= 1'b1;
            cnt_q           <= '0;
            state_q         <= StWDrain;
          end
        end
        StWDrain: begin
          cnt_q <= cnt_q + CntOne;
          if (last_cnt) begin
            m_write_valid_q <= 1'b0;
            s_req_ready_q   <= 1'b1;
            state_q         <= StIdle;
          end
        end
        StRIssue: begin
          if (m_req_ready) begin
            m_req_valid_q <= 1'b0;
            cnt_q         <= '0;
            state_q       <= StRData;
          end
        end
        StRData: begin
          if (rd_xfer) begin
            cnt_q <= cnt_q + CntOne;
            if (last_cnt) begin
              s_req_ready_q <= 1'b1;
              state_q       <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s_req_ready   = s_req_ready_q;
  assign m_req_valid   = m_req_valid_q;
  assign m_write_valid = m_write_valid_q;
  assign m_req_addr    = addr_q;
  assign m_req_mask    = mask_q;
  assign m_req_len     = len_q;
  assign m_req_we      = we_q;
  assign m_req_wrap    = wrap_q;

  assign s_read_valid  = (state_q == StRData) && m_read_valid;
  assign s_read_data   = m_read_data;
  assign m_read_ack    = (state_q == StRData) && s_read_ack;

`ifdef REQ_WBUF_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if ((s_write_valid && (state_q != StWCollect)) ||
                 (m_read_valid && (state_q != StRData)) ||
                 (s_read_ack && !s_read_valid)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_req_wbuf.sv
// Scoreboard bench for req_wbuf: stimulus queues expected responses, a monitor checks them.
module tb_req_wbuf;

  localparam int unsigned LW = 8;
  localparam int unsigned MW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned FW = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [MW-1:0] mask;
    logic [LW-1:0] len;
    logic          we;
    logic          wrap;
  } req_t;

  logic          clk, rstn;
  logic          s_req_valid, s_req_ready;
  logic [AW-1:0] s_req_addr;
  logic [MW-1:0] s_req_mask;
  logic [LW-1:0] s_req_len;
  logic          s_req_we, s_req_wrap;
  logic          s_write_valid;
  logic [DW-1:0] s_write_data;
  logic          s_read_valid;
  logic [DW-1:0] s_read_data;
  logic          s_read_ack;
  logic          m_req_valid, m_req_ready;
  logic [AW-1:0] m_req_addr;
  logic [MW-1:0] m_req_mask;
  logic [LW-1:0] m_req_len;
  logic          m_req_we, m_req_wrap;
  logic          m_write_valid;
  logic [DW-1:0] m_write_data;
  logic          m_read_valid;
  logic [DW-1:0] m_read_data;
  logic          m_read_ack;
`ifdef REQ_WBUF_ERR_EN
  logic          err;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  req_t          req_q[$];
  logic [DW-1:0] wd_q[$];
  logic [DW-1:0] rd_q[$];
  int            left;
  bit            done_prev;
  req_t          cur;

  req_wbuf #(
    .LW(LW), .MW(MW), .DW(DW), .AW(AW), .FW(FW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_req_valid  (s_req_valid),
    .s_req_ready  (s_req_ready),
    .s_req_addr   (s_req_addr),
    .s_req_mask   (s_req_mask),
    .s_req_len    (s_req_len),
    .s_req_we     (s_req_we),
    .s_req_wrap   (s_req_wrap),
    .s_write_valid(s_write_valid),
    .s_write_data (s_write_data),
    .s_read_valid (s_read_valid),
    .s_read_data  (s_read_data),
    .s_read_ack   (s_read_ack),
    .m_req_valid  (m_req_valid),
    .m_req_ready  (m_req_ready),
    .m_req_addr   (m_req_addr),
    .m_req_mask   (m_req_mask),
    .m_req_len    (m_req_len),
    .m_req_we     (m_req_we),
    .m_req_wrap   (m_req_wrap),
    .m_write_valid(m_write_valid),
    .m_write_data (m_write_data),
    .m_read_valid (m_read_valid),
    .m_read_data  (m_read_data),
    .m_read_ack   (m_read_ack)
`ifdef REQ_WBUF_ERR_EN
    ,
    .err          (err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t mk_req(input logic [AW-1:0] addr, input logic [MW-1:0] mask,
                                  input logic [LW-1:0] len, input logic we, input logic wrap);
    req_t r;
    r.addr = addr;
    r.mask = mask;
    r.len  = len;
    r.we   = we;
    r.wrap = wrap;
    return r;
  endfunction

  // Monitor: compares every DUT output event against the scoreboard queues.
  always @(negedge clk) begin
    if (!rstn) begin
      left      = 0;
      done_prev = 1'b0;
      req_q.delete();
      wd_q.delete();
      rd_q.delete();
    end else begin
      if (done_prev) chk("rdy_after_drain", s_req_ready, 1);
      done_prev = 1'b0;
      if (left > 0) begin
        chk("m_write_b2b", m_write_valid, 1);
        if (wd_q.size() == 0) chk("m_write_nodata", wd_q.size(), 1);
        else chk("m_write_data", m_write_data, wd_q.pop_front());
        left--;
        if (left == 0) done_prev = 1'b1;
      end else if (m_write_valid) begin
        chk("m_write_extra", m_write_valid, 0);
      end
      if (m_req_valid) begin
        if (req_q.size() == 0) begin
          chk("m_req_extra", m_req_valid, 0);
        end else begin
          cur = req_q[0];
          chk("m_req_fields", {m_req_addr, m_req_mask, m_req_len, m_req_we, m_req_wrap}, cur);
          if (m_req_ready) begin
            if (cur.we) left = int'(cur.len) + 1;
            void'(req_q.pop_front());
          end
        end
      end
      if (s_read_valid && s_read_ack) begin
        if (rd_q.size() == 0) chk("s_read_extra", s_read_valid, 0);
        else chk("s_read_data", s_read_data, rd_q.pop_front());
      end
    end
  end

  task automatic do_accept(input req_t r);
    bit got;
    @(posedge clk); #1;
    s_req_valid = 1'b1;
    s_req_addr  = r.addr;
    s_req_mask  = r.mask;
    s_req_len   = r.len;
    s_req_we    = r.we;
    s_req_wrap  = r.wrap;
    req_q.push_back(r);
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      got = s_req_ready;
    end
    if (!got) chk("accept_timeout", got, 1);
    @(posedge clk); #1;
    s_req_valid = 1'b0;
  endtask

  task automatic send_write(input req_t r, input logic [DW-1:0] base);
    do_accept(r);
    for (int i = 0; i <= int'(r.len); i++) begin
      s_write_valid = 1'b1;
      s_write_data  = base + DW'(i);
      wd_q.push_back(base + DW'(i));
      @(posedge clk); #1;
    end
    s_write_valid = 1'b0;
    @(negedge clk);
    chk("wr_issue_lat", m_req_valid, 1);
  endtask

  task automatic wait_idle(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      got = s_req_ready;
    end
    if (!got) chk(name, got, 1);
  endtask

  initial begin
    int  k, wcnt;
    bit  ack, seen, acc;
    rstn = 1'b0;
    s_req_valid = 1'b0; s_req_addr = '0; s_req_mask = '0; s_req_len = '0;
    s_req_we = 1'b0; s_req_wrap = 1'b0;
    s_write_valid = 1'b0; s_write_data = '0; s_read_ack = 1'b0;
    m_req_ready = 1'b0; m_read_valid = 1'b0; m_read_data = '0;

    // Reset
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_s_req_ready", s_req_ready, 0);
    chk("rst_m_req_valid", m_req_valid, 0);
    chk("rst_m_write_valid", m_write_valid, 0);
    chk("rst_m_read_ack", m_read_ack, 0);
    chk("rst_s_read_valid", s_read_valid, 0);
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("rdy_before_edge", s_req_ready, 0);
    @(negedge clk);
    chk("rdy_after_rst", s_req_ready, 1);

    // Single write, ready tied high
    m_req_ready = 1'b1;
    send_write(mk_req(32'h0000_0100, 4'hf, 8'd0, 1'b1, 1'b0), 32'hDEAD_BEEF);
    wait_idle("single_done");

    // Full burst with stalled downstream
    m_req_ready = 1'b0;
    send_write(mk_req(32'h0000_2000, 4'h3, 8'd255, 1'b1, 1'b1), 32'h1000_0000);
    repeat (10) @(negedge clk);
    @(posedge clk); #1 m_req_ready = 1'b1;
    wait_idle("burst_done");

    // Read burst, len 3, wrap, toggling ack
    do_accept(mk_req(32'h0000_3000, 4'h5, 8'd3, 1'b0, 1'b1));
    @(negedge clk);
    chk("rd_issue_lat", m_req_valid, 1);
    @(posedge clk); #1;
    k = 0;
    ack = 1'b1;
    for (int c = 0; c < 20 && k < 4; c++) begin
      m_read_valid = 1'b1;
      m_read_data  = 32'hA000_0000 + DW'(k);
      s_read_ack   = ack;
      if (ack) rd_q.push_back(m_read_data);
      @(negedge clk);
      chk("rd_fwd_valid", s_read_valid, 1);
      chk("rd_ack_mirror", m_read_ack, ack);
      @(posedge clk); #1;
      if (ack) k++;
      ack = !ack;
    end
    m_read_valid = 1'b0;
    s_read_ack   = 1'b0;
    @(negedge clk);
    chk("rd_idle", s_req_ready, 1);
    chk("rd_count", k, 4);
    chk("rd_drained", rd_q.size(), 0);

    // Ordering: read pending behind an 8-word write
    send_write(mk_req(32'h0000_4000, 4'hc, 8'd7, 1'b1, 1'b0), 32'h5000_0000);
    @(posedge clk); #1;
    s_req_valid = 1'b1; s_req_addr = 32'h0000_4800; s_req_mask = 4'ha;
    s_req_len = 8'd0; s_req_we = 1'b0; s_req_wrap = 1'b0;
    req_q.push_back(mk_req(32'h0000_4800, 4'ha, 8'd0, 1'b0, 1'b0));
    wcnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (m_write_valid) wcnt++;
      if (m_req_valid && !m_req_we) seen = 1'b1;
      acc = s_req_ready && s_req_valid;
      @(posedge clk); #1;
      if (acc) s_req_valid = 1'b0;
    end
    chk("order_seen", seen, 1);
    chk("order_wcnt", wcnt, 8);
    m_read_valid = 1'b1;
    m_read_data  = 32'hBEEF_0001;
    s_read_ack   = 1'b1;
    rd_q.push_back(32'hBEEF_0001);
    @(negedge clk);
    chk("order_rd_valid", s_read_valid, 1);
    @(posedge clk); #1;
    m_read_valid = 1'b0;
    s_read_ack   = 1'b0;
    wait_idle("order_done");

    // Reset in the middle of a drain, then a fresh single write
    send_write(mk_req(32'h0000_6000, 4'hf, 8'd7, 1'b1, 1'b0), 32'h7000_0000);
    wcnt = 0;
    for (int c = 0; c < 50 && wcnt < 3; c++) begin
      @(negedge clk);
      if (m_write_valid) wcnt++;
    end
    @(posedge clk); #1 rstn = 1'b0;
    @(negedge clk);
    chk("rst_mid_mwv", m_write_valid, 0);
    chk("rst_mid_rdy", s_req_ready, 0);
    @(posedge clk); #1 rstn = 1'b1;
    wait_idle("rst_recover");
    send_write(mk_req(32'h0000_8000, 4'h1, 8'd0, 1'b1, 1'b0), 32'h5555_AAAA);
    wait_idle("post_rst_done");
    repeat (5) @(negedge clk);
    chk("wd_drained", wd_q.size(), 0);

`ifdef REQ_WBUF_ERR_EN
    chk("err_clear", err, 0);
    @(posedge clk); #1 s_write_valid = 1'b1;
    @(posedge clk); #1 s_write_valid = 1'b0;
    @(negedge clk);
    chk("err_set", err, 1);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
